// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
// Optional feature macro: IMEM_CHECKSUM_EN (see rtl/imem_boot_ctrl.sv).
package imem_boot_pkg;

  localparam int unsigned IMEM_N     = 32;
  localparam int unsigned IMEM_AW    = 6;
  localparam int unsigned IMEM_DEPTH = 64;

  // Value written into every location not covered by the program
  localparam logic [IMEM_N-1:0] IMEM_ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CLEAR,
    ST_RUN
  } boot_state_e;

  // Build the word being committed from the bytes held so far plus the
  // current byte; bytes not yet received become 0x00 (big-endian order).
  function automatic logic [31:0] pad_word(input logic [23:0] sh,
                                           input logic [1:0]  cnt,
                                           input logic [7:0]  b);
    logic [31:0] w;
    case (cnt)
      2'd0:    w = {b, 24'h000000};
      2'd1:    w = {sh[7:0], b, 16'h0000};
      2'd2:    w = {sh[15:0], b, 8'h00};
      default: w = {sh, b};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Byte-serial loader handshake between the program source and the controller.
interface imem_boot_ctrl_if;

  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_byte;
  logic       ld_last;

  // Program source side
  modport master (
    output ld_valid,
    output ld_byte,
    output ld_last,
    input  ld_ready
  );

  // Controller side
  modport slave (
    input  ld_valid,
    input  ld_byte,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/imem_boot_ctrl_ram.sv
// Instruction RAM: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module imem_ram #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  q
);

  logic [N-1:0] mem [2**AW];

  // Write port: commits on the clock edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: zero-latency for single-cycle fetch
  always_comb begin
    q = mem[raddr];
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller for the instruction memory: assembles loader bytes into
// words, zero-fills the remainder, then releases the CPU and serves fetches.
// Optional feature macro: IMEM_CHECKSUM_EN adds the ld_sum checksum port.
import imem_boot_pkg::*;

module imem_boot_ctrl #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
) (
  input  logic            clk,
  input  logic            reset,
  imem_boot_ctrl_if.slave ld,
  input  logic            reload,
  input  logic [AW-1:0]   fetch_addr,
  output logic [N-1:0]    fetch_q,
  output logic            cpu_run,
  output logic            ld_err
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic [N-1:0]    ld_sum
`endif
);

  boot_state_e   state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   sh_q, sh_d;
  logic          err_q, err_d;
`ifdef IMEM_CHECKSUM_EN
  logic [N-1:0]  sum_q, sum_d;
`endif

  logic          accept;
  logic          we;
  logic [N-1:0]  wdata;
  logic [N-1:0]  word;
  logic [N-1:0]  ram_q;

  // Loader handshake: bytes accepted only while loading
  always_comb begin
    ld.ld_ready = (state_q == ST_LOAD);
    accept      = ld.ld_valid && ld.ld_ready;
  end

  // State and datapath registers, synchronous active-low reset (RAM excluded)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      wptr_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      err_q   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      err_q   <= err_d;
`ifdef IMEM_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next-state, word assembly and RAM write control
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    err_d   = err_q;
`ifdef IMEM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    we      = 1'b0;
    wdata   = IMEM_ZERO_WORD;
    word    = pad_word(sh_q, bcnt_q, ld.ld_byte);

    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (ld.ld_last || (bcnt_q == 2'd3)) begin
            we     = 1'b1;
            wdata  = word;
            wptr_d = wptr_q + 1'b1;
            bcnt_d = '0;
            sh_d   = '0;
`ifdef IMEM_CHECKSUM_EN
            sum_d  = sum_q + word;
`endif
            if (ld.ld_last) begin
              // Word 63 as the final word leaves nothing to clear
              state_d = (wptr_q == '1) ? ST_RUN : ST_CLEAR;
            end else if (wptr_q == '1) begin
              state_d = ST_RUN;
              err_d   = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
            sh_d   = {sh_q[15:0], ld.ld_byte};
          end
        end
      end

      ST_CLEAR: begin
        we     = 1'b1;
        wdata  = IMEM_ZERO_WORD;
        wptr_d = wptr_q + 1'b1;
        if (wptr_q == '1) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (reload) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          bcnt_d  = '0;
          sh_d    = '0;
          err_d   = 1'b0;
`ifdef IMEM_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Fetch path: CPU sees zeros and is stalled until the program is resident
  always_comb begin
    cpu_run = (state_q == ST_RUN);
    fetch_q = cpu_run ? ram_q : '0;
    ld_err  = err_q;
`ifdef IMEM_CHECKSUM_EN
    ld_sum  = sum_q;
`endif
  end

  imem_ram #(
    .N  (N),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (fetch_addr),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a word-level scoreboard.
// Build with IMEM_CHECKSUM_EN defined to also check ld_sum.
module tb_imem_boot_ctrl;
  import imem_boot_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reload = 1'b0;
  logic [5:0]  fetch_addr = '0;
  logic [31:0] fetch_q;
  logic        cpu_run;
  logic        ld_err;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0] ld_sum;
`endif

  imem_boot_ctrl_if lif ();

  imem_boot_ctrl #(
    .N  (32),
    .AW (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld         (lif),
    .reload     (reload),
    .fetch_addr (fetch_addr),
    .fetch_q    (fetch_q),
    .cpu_run    (cpu_run),
    .ld_err     (ld_err)
`ifdef IMEM_CHECKSUM_EN
    ,
    .ld_sum     (ld_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Bench-side loader model
  logic [5:0]  m_wptr;
  logic [1:0]  m_bcnt;
  logic [31:0] m_acc;
  logic [31:0] m_sum;
  bit          m_wrapped;

  logic [7:0]  t1 [8]  = '{8'hf8, 8'h00, 8'h00, 8'h01, 8'hf8, 8'h00, 8'h80, 8'h02};
  logic [7:0]  t2 [6]  = '{8'hab, 8'hcd, 8'hef, 8'h01, 8'h12, 8'h34};
  logic [7:0]  t4 [4]  = '{8'h8b, 8'h1f, 8'h01, 8'h87};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wptr    = '0;
    m_bcnt    = '0;
    m_acc     = '0;
    m_sum     = '0;
    m_wrapped = 1'b0;
    exp_q.delete();
  endtask

  // Present one byte and hold it until accepted (bounded); updates the model
  task automatic send_byte(input logic [7:0] b, input logic last);
    int unsigned n;
    exp_t e;
    n = 0;
    lif.ld_valid = 1'b1;
    lif.ld_byte  = b;
    lif.ld_last  = last;
    while (!lif.ld_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      check("ld_accept_timeout", 32'(n), 32'd0);
      lif.ld_valid = 1'b0;
      lif.ld_last  = 1'b0;
    end else begin
      @(posedge clk); #1;
      lif.ld_valid = 1'b0;
      lif.ld_last  = 1'b0;
      m_acc = m_acc | ({b, 24'h000000} >> (8 * int'(m_bcnt)));
      if (last || m_bcnt == 2'd3) begin
        e.addr = m_wptr;
        e.word = m_acc;
        exp_q.push_back(e);
        m_sum = m_sum + m_acc;
        if (m_wptr == 6'd63) m_wrapped = 1'b1;
        m_wptr = m_wptr + 6'd1;
        m_bcnt = '0;
        m_acc  = '0;
      end else begin
        m_bcnt = m_bcnt + 2'd1;
      end
    end
  endtask

  task automatic flush_zeros();
    exp_t e;
    if (!m_wrapped) begin
      for (int a = int'(m_wptr); a < 64; a++) begin
        e.addr = 6'(a);
        e.word = '0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_run(input string tag, input logic [31:0] exp_cycles);
    int unsigned n;
    n = 0;
    while (!cpu_run && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(n), exp_cycles);
  endtask

  task automatic sweep(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      fetch_addr = e.addr;
      #1;
      check($sformatf("%s[%0d]", tag, e.addr), fetch_q, e.word);
    end
  endtask

  task automatic do_reload(input string tag);
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check({tag, "_ready"}, 32'(lif.ld_ready), 32'd1);
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    lif.ld_valid = 1'b0;
    lif.ld_byte  = '0;
    lif.ld_last  = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_ready", 32'(lif.ld_ready), 32'd1);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_fetch_q", fetch_q, 32'd0);
    check("rst_ld_err", 32'(ld_err), 32'd0);
`ifdef IMEM_CHECKSUM_EN
    check("rst_ld_sum", ld_sum, 32'd0);
`endif

    // Two-word program, ld_last on a full word
    for (int i = 0; i < 8; i++) send_byte(t1[i], i == 7);
    flush_zeros();
    wait_run("t1_clear_cycles", 32'd62);
    fetch_addr = 6'd1;
    #1;
    check("t1_fetch1", fetch_q, 32'hf8008002);
    check("t1_ld_err", 32'(ld_err), 32'd0);
    sweep("t1_mem");

    // Partial last word padded with zeros
    do_reload("t2_reload");
    for (int i = 0; i < 6; i++) send_byte(t2[i], i == 5);
    flush_zeros();
    wait_run("t2_clear_cycles", 32'd62);
    fetch_addr = 6'd1;
    #1;
    check("t2_fetch1", fetch_q, 32'h12340000);
`ifdef IMEM_CHECKSUM_EN
    check("t2_ld_sum", ld_sum, 32'hbe01ef01);
`endif
    sweep("t2_mem");

    // Overflow: 256 bytes without ld_last
    do_reload("t3_reload");
    for (int i = 0; i < 256; i++) send_byte(8'(i * 7 + 3), 1'b0);
    check("t3_cpu_run", 32'(cpu_run), 32'd1);
    check("t3_ld_err", 32'(ld_err), 32'd1);
    check("t3_ready", 32'(lif.ld_ready), 32'd0);
    lif.ld_valid = 1'b1;
    lif.ld_byte  = 8'hee;
    lif.ld_last  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    lif.ld_valid = 1'b0;
    lif.ld_last  = 1'b0;
    check("t3_257_ready", 32'(lif.ld_ready), 32'd0);
    check("t3_257_cpu_run", 32'(cpu_run), 32'd1);
`ifdef IMEM_CHECKSUM_EN
    check("t3_ld_sum", ld_sum, m_sum);
`endif
    flush_zeros();
    sweep("t3_mem");

    // Reload after overflow clears the error
    do_reload("t4_reload");
    check("t4_err_cleared", 32'(ld_err), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(t4[i], i == 3);
    flush_zeros();
    wait_run("t4_clear_cycles", 32'd63);
    fetch_addr = 6'd0;
    #1;
    check("t4_fetch0", fetch_q, 32'h8b1f0187);
    check("t4_ld_err", 32'(ld_err), 32'd0);
    sweep("t4_mem");

    // Reset mid-word abandons the partial word
    do_reload("t5_reload_a");
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), i == 15);
    flush_zeros();
    wait_run("t5_clear_cycles_a", 32'd60);
    sweep("t5_mem_a");
    do_reload("t5_reload_b");
    for (int i = 0; i < 14; i++) send_byte(8'(8'h80 + i), 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    fetch_addr = 6'd3;
    #1;
    check("t5_rst_ready", 32'(lif.ld_ready), 32'd1);
    check("t5_rst_cpu_run", 32'(cpu_run), 32'd0);
    check("t5_rst_ld_err", 32'(ld_err), 32'd0);
    check("t5_rst_fetch_q", fetch_q, 32'd0);
    check("t5_word3_kept", dut.u_ram.mem[3], 32'h1c1d1e1f);
    check("t5_word2_kept", dut.u_ram.mem[2], 32'h88898a8b);
    model_reset();
    for (int i = 0; i < 4; i++) send_byte(8'(8'hc0 + i), i == 3);
    flush_zeros();
    wait_run("t5_clear_cycles_b", 32'd63);
    fetch_addr = 6'd0;
    #1;
    check("t5_fetch0", fetch_q, 32'hc0c1c2c3);
    sweep("t5_mem_b");

    // Bubbles between bytes; a reload pulse while loading is ignored
    do_reload("t6_reload");
    for (int i = 0; i < 4; i++) begin
      send_byte(t4[i], i == 3);
      if (i < 3) begin
        repeat (10) begin
          if (i == 1) reload = 1'b1;
          @(posedge clk); #1;
          reload = 1'b0;
        end
        check($sformatf("t6_gap%0d_ready", i), 32'(lif.ld_ready), 32'd1);
      end
    end
    flush_zeros();
    wait_run("t6_clear_cycles", 32'd63);
    fetch_addr = 6'd0;
    #1;
    check("t6_fetch0", fetch_q, 32'h8b1f0187);
    sweep("t6_mem");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
